// File: rtl/cargador_pkg.sv
// Shared constants and state encoding for the program loader.
// Checksum support is selected with the CARGADOR_CHECKSUM_EN macro in the top module.
package cargador_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int MAX_WORDS  = (1 << ADDR_W) / WORD_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE
  } estado_t;

endpackage

// File: rtl/cargador_programa_if.sv
// Byte-stream handshake plus instruction-memory write bus of the program loader.
// The loader uses the slave modport; the byte source / memory side uses master.
interface cargador_programa_if #(
  parameter int ADDR_W = cargador_pkg::ADDR_W,
  parameter int DATA_W = cargador_pkg::DATA_W
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_dir;
  logic [DATA_W-1:0] mem_dato;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_dir, mem_dato
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_dir, mem_dato
  );

endinterface

// File: rtl/ensamblador_palabra.sv
// Big-endian word assembler: 4-byte shift register with byte counter and clear.
// completo_o flags the cycle in which the fourth byte of a word is being shifted in.
module ensamblador_palabra
  import cargador_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [7:0]                byte_i,
  output logic [WORD_BYTES*8-1:0]   palabra_o,
  output logic                      completo_o
);

  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign completo_o = en_i && (cnt_q == CW'(WORD_BYTES - 1));

  // Byte slot 0 takes the newest byte, so the first byte of a word ends up in the top slot.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
      logic [7:0] b_q;
      logic [7:0] ent;

      if (gi == 0) begin : g_ent
        assign ent = byte_i;
      end else begin : g_ent
        assign ent = g_byte[gi-1].b_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          b_q <= '0;
        end else if (clr_i) begin
          b_q <= '0;
        end else if (en_i) begin
          b_q <= ent;
        end
      end

      assign palabra_o[8*gi +: 8] = b_q;
    end
  endgenerate

endmodule

// File: rtl/cargador_programa.sv
// Program loader: streams bytes into big-endian words written at consecutive word addresses,
// stalling the datapath while loading. Define CARGADOR_CHECKSUM_EN for the trailing XOR check.
module cargador_programa
  import cargador_pkg::*;
#(
  parameter int ADDR_W    = cargador_pkg::ADDR_W,
  parameter int DATA_W    = cargador_pkg::DATA_W,
  parameter int MAX_WORDS = cargador_pkg::MAX_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inicio,
  cargador_programa_if.slave  bus,
  output logic                hold_cpu,
  output logic                listo,
  output logic                error
);

  localparam int KW = $clog2(MAX_WORDS + 1);

  estado_t       estado_q, estado_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] n_q, n_d;
  logic          limpiar;
  logic          acc_datos;
  logic          completo;
  logic [WORD_BYTES*8-1:0] palabra;

  ensamblador_palabra u_ensamblador (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (limpiar),
    .en_i       (acc_datos),
    .byte_i     (bus.byte_data),
    .palabra_o  (palabra),
    .completo_o (completo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= ST_IDLE;
      k_q      <= '0;
      n_q      <= '0;
    end else begin
      estado_q <= estado_d;
      k_q      <= k_d;
      n_q      <= n_d;
    end
  end

  always_comb begin
    estado_d       = estado_q;
    k_d            = k_q;
    n_d            = n_q;
    limpiar        = 1'b0;
    acc_datos      = 1'b0;
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    hold_cpu       = 1'b0;
    listo          = 1'b0;

    case (estado_q)
      ST_IDLE: begin
        if (inicio) begin
          limpiar  = 1'b1;
          k_d      = '0;
          estado_d = ST_LEN;
        end
      end

      ST_LEN: begin
        bus.byte_ready = 1'b1;
        hold_cpu       = 1'b1;
        if (bus.byte_valid) begin
          // Bit 7 of the length byte is deliberately ignored: N ranges 1..128.
          n_d      = KW'(bus.byte_data[6:0]) + KW'(1);
          estado_d = ST_DATA;
        end
      end

      ST_DATA: begin
        bus.byte_ready = 1'b1;
        hold_cpu       = 1'b1;
        acc_datos      = bus.byte_valid;
        if (completo) begin
          estado_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        bus.mem_we = 1'b1;
        hold_cpu   = 1'b1;
        k_d        = k_q + KW'(1);
        if (k_d == n_q) begin
`ifdef CARGADOR_CHECKSUM_EN
          estado_d = ST_CHK;
`else
          estado_d = ST_DONE;
`endif
        end else begin
          estado_d = ST_DATA;
        end
      end

`ifdef CARGADOR_CHECKSUM_EN
      ST_CHK: begin
        bus.byte_ready = 1'b1;
        hold_cpu       = 1'b1;
        if (bus.byte_valid) begin
          estado_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        listo    = 1'b1;
        estado_d = ST_IDLE;
      end

      default: begin
        estado_d = ST_IDLE;
      end
    endcase
  end

  // Word index k maps to byte address 4*k; N never exceeds capacity so no wrap occurs.
  assign bus.mem_dir  = ADDR_W'({k_q, 2'b00});
  assign bus.mem_dato = DATA_W'(palabra);

`ifdef CARGADOR_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q   <= '0;
      error_q <= 1'b0;
    end else begin
      if (limpiar) begin
        xor_q   <= '0;
        error_q <= 1'b0;
      end else if (acc_datos) begin
        xor_q <= xor_q ^ bus.byte_data;
      end
      if ((estado_q == ST_CHK) && bus.byte_valid && (bus.byte_data != xor_q)) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
